// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module  : shift_add_multiplier
// Brief   : Sequential unsigned shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH).
//           Optional macro MULT_EARLY_TERM_EN ends the run once the multiplier
//           has no set bits left.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] P
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mult_q, mult_d;
  logic [PW-1:0]   acc_q,   acc_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [PW-1:0]   p_q,     p_d;

  logic [PW-1:0]   sum;
  logic            last;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sum     = acc_q + (mult_q[0] ? mcand_q : '0);
`ifdef MULT_EARLY_TERM_EN
    // cnt remains a backstop; the shifted-out multiplier usually ends first
    last    = (cnt_q == CW'(1)) || (mult_q[WIDTH-1:1] == '0);
`else
    last    = (cnt_q == CW'(1));
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          mcand_d = {{WIDTH{1'b0}}, A};
          mult_d  = B;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (last) begin
          p_d     = sum;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_DONE);
  assign P    = p_q;

endmodule

`default_nettype wire

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-add multiplier; the product stage directly upstream of the MAC unit's 8-bit ripple adder.
- Takes two WIDTH-bit operands on a START strobe and produces a 2*WIDTH-bit product. With the default WIDTH=4 the product is 8 bits and drives the adder's A input.
- Area-lean: one 2*WIDTH-bit add per cycle, controlled by a 3-state FSM.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH; legal range 2..16.

Ports:
- CLK  input  1  single clock; rising-edge triggered.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a multiply; sampled on the rising edge.
- A  input  WIDTH  multiplicand; captured when START is accepted.
- B  input  WIDTH  multiplier; captured when START is accepted.
- BUSY  output  1  high while state is RUN.
- DONE  output  1  single-cycle pulse; P is valid in that cycle.
- P  output  2*WIDTH  product; held stable from DONE until the next accepted START.

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - Reset is synchronous and active-high on RST, checked at the rising edge and taking priority over everything else.
  - RST=1 forces: state=IDLE, BUSY=0, DONE=0, P=0, all internal registers 0.
  - Reset asserted mid-RUN aborts the operation. No DONE is produced for it.
- Internal registers:
  - mcand: 2*WIDTH bits.
  - mult: WIDTH bits.
  - acc: 2*WIDTH bits.
  - cnt: clog2(WIDTH+1) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If START=1: mcand={0,A}, mult=B, acc=0, cnt=WIDTH; go to RUN.
  - Otherwise stay in IDLE.
- RUN (BUSY=1), on each edge:
  - If mult[0]=1 then acc=acc+mcand (modulo 2^(2*WIDTH); overflow is impossible).
  - mcand=mcand<<1; mult=mult>>1; cnt=cnt-1.
  - If cnt==1: P gets the final acc value and the state goes to DONE.
  - START is ignored in RUN. A and B may change freely without effect.
- DONE (DONE=1, BUSY=0, lasts exactly one cycle):
  - If START=1: reload the operands as in IDLE and go to RUN (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
  - P keeps its value in both cases.
- Latency:
  - START sampled at edge n gives DONE=1 in the cycle after edge n+WIDTH (4 cycles by default).
  - Back-to-back throughput is one result every WIDTH+1 cycles.
- Outputs:
  - All outputs are registered or decoded from the state register only. No combinational path from an input to an output.
  - P changes only on the edge that enters DONE, or on reset.
- Arithmetic: unsigned only. Maximum product (2^WIDTH-1)^2 always fits in 2*WIDTH bits.
- Boundary conditions:
  - A=0 or B=0: normal latency, P=0.
  - START held high continuously: an operation starts at every opportunity (IDLE or DONE).
  - RST and START asserted together: reset wins.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined (early termination):
  - In RUN, the block also goes to DONE when the post-shift value of mult is 0.
  - The product is identical to the non-early-termination result.
  - Latency = max(1, index of the highest set bit of B + 1) cycles. For B=0 or B=1, DONE follows one RUN cycle.
  - cnt is still used as a backstop.
- Undefined: fixed latency of WIDTH cycles, as specified above. No extra logic is generated.

Test Plan:
- Reset then START with A=3, B=5 -> BUSY high for 4 cycles; DONE pulses once; P=8'd15; P still 15 two cycles later.
- A=15, B=15 -> P=8'd225. Then A=0, B=9 -> P=0 with full 4-cycle latency (no MULT_EARLY_TERM_EN).
- START with A=7, B=6, then pulse START with A=1, B=1 during RUN -> second request ignored; P=42; exactly one DONE pulse.
- START held high with pairs (2,3) then (4,4) -> DONE pulses 5 cycles apart; P=6 then P=16; no IDLE cycle between the operations.
- START with A=9, B=9, RST asserted in the 2nd RUN cycle -> next cycle BUSY=0, DONE=0, P=0; no DONE for 10 cycles.
- With MULT_EARLY_TERM_EN: A=13, B=1 -> DONE one cycle after RUN entry, P=13; A=13, B=2 -> two-cycle latency, P=26; A=13, B=8 -> four-cycle latency, P=104.
